// File: rtl/chrom_input_capture_bank.sv
// Multi-channel Avalon-MM input capture bank: synchronises chromosome error/fitness words,
// flags per-channel changes, counts change cycles and raises a maskable IRQ.
// Optional shadow-snapshot reads are enabled by defining CHROM_CAPTURE_SNAPSHOT_EN.
module chrom_input_capture_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [3:0]                   address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  input  logic [CHANNELS*WIDTH-1:0]    in_port,
  output logic [31:0]                  readdata,
  output logic                         irq
);

  localparam int DW = CHANNELS * WIDTH;

  logic [DW-1:0]       s1_q, s2_q, prev_q;
  logic [DW-1:0]       chan_src;
  logic [CHANNELS-1:0] chg;
  logic [CHANNELS-1:0] change_q, change_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q;
  logic                wr_en;
  logic                unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

`ifdef CHROM_CAPTURE_SNAPSHOT_EN
  logic          snap_q, snap_d;
  logic [DW-1:0] shadow_q, shadow_d;

  assign chan_src = snap_q ? shadow_q : s2_q;

  // Capture uses the pre-edge s2 value, so a coincident input change is not seen.
  always_comb begin
    snap_d   = snap_q;
    shadow_d = shadow_q;
    if (wr_en && address == 4'd11) begin
      snap_d = writedata[0];
      if (writedata[0]) shadow_d = s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      snap_q   <= snap_d;
      shadow_q <= shadow_d;
    end
  end
`else
  assign chan_src = s2_q;
`endif

  always_comb begin
    chg = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      chg[i] = (s2_q[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]);
    end
  end

  // A new change in the same cycle as its W1C keeps the bit set.
  always_comb begin
    change_d = change_q;
    if (wr_en && address == 4'd8) change_d = change_q & ~writedata[CHANNELS-1:0];
    change_d = change_d | chg;

    mask_d = mask_q;
    if (wr_en && address == 4'd9) mask_d = writedata[CHANNELS-1:0];

    count_d = count_q;
    if (wr_en && address == 4'd10) begin
      count_d = '0;
    end else if (|chg && count_q != {COUNT_W{1'b1}}) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_comb begin
    readdata_d = '0;
    if (!address[3]) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (address[2:0] == 3'(i)) readdata_d[WIDTH-1:0] = chan_src[i*WIDTH +: WIDTH];
      end
    end else begin
      case (address[2:0])
        3'd0:    readdata_d[CHANNELS-1:0] = change_q;
        3'd1:    readdata_d[CHANNELS-1:0] = mask_q;
        3'd2:    readdata_d[COUNT_W-1:0]  = count_q;
`ifdef CHROM_CAPTURE_SNAPSHOT_EN
        3'd3:    readdata_d[0]            = snap_q;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      change_q   <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      change_q   <= change_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      irq_q      <= |(change_q & mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
